// File: rtl/sevenseg_reader_if.sv
// Seven-segment display bus as seen by the reader: the multiplexed
// segment/anode lines plus the recovered digits and status flags.
interface sevenseg_reader_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_done;
  logic                    bad_pattern;
  logic                    overlap_err;

  modport master (
    output seg_n, an_n,
    input  digits, digit_valid, frame_done, bad_pattern, overlap_err
  );

  modport slave (
    input  seg_n, an_n,
    output digits, digit_valid, frame_done, bad_pattern, overlap_err
  );
endinterface

// File: rtl/sevenseg_reader.sv
// Recovers BCD digits from a multiplexed active-low seven-segment bus,
// committing a digit only after STABLE_CYCLES identical samples.
module sevenseg_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input logic              clock,
  input logic              reset,
  sevenseg_reader_if.slave bus
);
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0] CMAX = 8'(STABLE_CYCLES);

  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    s_vld_q, s_vld_d;
  logic [6:0]              prev_seg_q, prev_seg_d;
  logic [IDXW-1:0]         prev_idx_q, prev_idx_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    frame_q, frame_d;
  logic                    bad_q, bad_d;
  logic                    ovl_q, ovl_d;

  logic [3:0]      zeros;
  logic [IDXW-1:0] sel_idx;
  logic            is_sel, is_ovl, commit;
  logic [4:0]      dec;

  // {legal, value}; anything outside the ten digit glyphs is illegal
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: return {1'b1, 4'd0};
      7'b1111001: return {1'b1, 4'd1};
      7'b0100100: return {1'b1, 4'd2};
      7'b0110000: return {1'b1, 4'd3};
      7'b0011001: return {1'b1, 4'd4};
      7'b0010010: return {1'b1, 4'd5};
      7'b0000010: return {1'b1, 4'd6};
      7'b1111000: return {1'b1, 4'd7};
      7'b0000000: return {1'b1, 4'd8};
      7'b0010000: return {1'b1, 4'd9};
      default:    return {1'b0, 4'd0};
    endcase
  endfunction

  // s_vld_q masks the all-zero reset content of the input register,
  // which would otherwise classify as an overlap sample.
  always_comb begin
    zeros   = 4'd0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        zeros   = zeros + 4'd1;
        sel_idx = IDXW'(i);
      end
    end
    is_sel = s_vld_q && (zeros == 4'd1);
    is_ovl = s_vld_q && (zeros > 4'd1);
  end

  always_comb begin
    seg_d      = bus.seg_n;
    an_d       = bus.an_n;
    s_vld_d    = 1'b1;
    prev_seg_d = prev_seg_q;
    prev_idx_d = prev_idx_q;
    cnt_d      = cnt_q;
    digits_d   = digits_q;
    valid_d    = valid_q;
    mask_d     = mask_q;
    frame_d    = 1'b0;
    bad_d      = 1'b0;
    ovl_d      = ovl_q | is_ovl;
    commit     = 1'b0;
    dec        = decode(seg_q);

    if (is_sel) begin
      prev_seg_d = seg_q;
      prev_idx_d = sel_idx;
      if (cnt_q != 8'd0 && sel_idx == prev_idx_q && seg_q == prev_seg_q) begin
        if (cnt_q != CMAX) begin
          cnt_d  = cnt_q + 8'd1;
          commit = (cnt_q + 8'd1 == CMAX);
        end
      end else begin
        cnt_d = 8'd1;
      end
    end else begin
      cnt_d = 8'd0;
    end

    // A commit in the clearing cycle lands in the fresh mask.
    if (&mask_q) begin
      frame_d = 1'b1;
      mask_d  = '0;
    end

    if (commit) begin
      mask_d[sel_idx] = 1'b1;
      if (dec[4]) begin
        digits_d[4*int'(sel_idx) +: 4] = dec[3:0];
        valid_d[sel_idx]               = 1'b1;
      end else begin
        valid_d[sel_idx] = 1'b0;
        bad_d            = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_q      <= '0;
      an_q       <= '0;
      s_vld_q    <= 1'b0;
      prev_seg_q <= '0;
      prev_idx_q <= '0;
      cnt_q      <= '0;
      digits_q   <= '0;
      valid_q    <= '0;
      mask_q     <= '0;
      frame_q    <= 1'b0;
      bad_q      <= 1'b0;
      ovl_q      <= 1'b0;
    end else begin
      seg_q      <= seg_d;
      an_q       <= an_d;
      s_vld_q    <= s_vld_d;
      prev_seg_q <= prev_seg_d;
      prev_idx_q <= prev_idx_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      mask_q     <= mask_d;
      frame_q    <= frame_d;
      bad_q      <= bad_d;
      ovl_q      <= ovl_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_done  = frame_q;
  assign bus.bad_pattern = bad_q;
  assign bus.overlap_err = ovl_q;
endmodule

// File: doc/sevenseg_reader.md
# sevenseg_reader

Monitor that watches a time-multiplexed seven-segment display bus (active-low segments plus active-low digit anodes) and recovers the BCD value shown on each digit. It applies the inverse of the team's segment encoding, with a per-sample stability filter. It sits beside the display driver in the pipelined-CPU top level. Its packed digit word and flags feed the self-check logic and the on-board debug readout.

## Interface
- NUM_DIGITS, default 4: number of multiplexed digits/anodes (range 1–8).
- STABLE_CYCLES, default 3: consecutive identical samples required before a digit is committed (range 2–255).

- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- seg_n  in  7  segment lines, active-low, bit6=g … bit0=a.
- an_n  in  NUM_DIGITS  anode enables, active-low, bit i = digit i.
- digits  out  4*NUM_DIGITS  recovered BCD, digit i in bits [4i+3:4i].
- digit_valid  out  NUM_DIGITS  bit i = 1 when the last commit of digit i was a legal pattern.
- frame_done  out  1  one-cycle pulse when every digit has committed since the previous pulse.
- bad_pattern  out  1  one-cycle pulse on commit of an undecodable pattern.
- overlap_err  out  1  sticky; set when more than one anode is sampled active.

## Operation
- Input stage: seg_n and an_n are registered once (sample s). No synchronizer; the source is same-clock.
- Sample classification:
  - "idle": an_n all ones.
  - "overlap": more than one zero in an_n.
  - "select i": exactly one zero, at bit i.
- Stability counter cnt:
  - Sample equal to the previous sample (same index, same seg_n) and select-type: cnt increments, saturating at STABLE_CYCLES.
  - New select-type sample: cnt = 1.
  - Idle or overlap sample: cnt = 0.
- Commit: fires on the cycle cnt transitions to STABLE_CYCLES. It fires once per stable run; holding longer produces no further commits.
- Decode table (seg_n → value):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9
- Legal commit: digits slot i = value, digit_valid[i] = 1.
- Illegal commit (any other pattern, including blank 1111111):
  - digits slot i unchanged, digit_valid[i] = 0.
  - bad_pattern pulses.
- Frame tracking: an internal mask sets bit i on every commit of digit i, legal or not.
  - When the mask becomes all ones, frame_done pulses on the following cycle and the mask clears in that same cycle.
  - A commit landing in the clearing cycle sets its bit in the fresh mask; it is not lost.
- Overlap: overlap_err is set on any overlap sample and stays set until reset. No commit occurs for overlap samples.

## Timing
- Reset values: digits = 0, digit_valid = 0, frame_done = 0, bad_pattern = 0, overlap_err = 0. The input register, cnt and mask are all 0.
- Latency: inputs held constant from before edge 1 → digits/digit_valid updated at edge STABLE_CYCLES+1. bad_pattern pulses at that same edge.
- frame_done rises one edge after the completing commit and lasts exactly one cycle.
- Run shorter than STABLE_CYCLES samples: no state change except cnt.
- A segment change while the anode is unchanged restarts cnt at 1.
- An anode change with unchanged segments also restarts cnt at 1.
- Reset asserted mid-run: outputs drop to reset values immediately (asynchronous). A partial run is discarded and counting restarts from the first sample after reset release.

## Test plan
- Reset: hold reset 3 cycles with random bus activity → all outputs 0. Release with an_n = 1111 → outputs stay 0.
- Single commit: an_n = 1110, seg_n = 0100100 held 5 cycles (STABLE_CYCLES = 3) → digits[3:0] = 2 and digit_valid = 0001 at edge 4. No bad_pattern.
- Glitch rejection: an_n = 1101, seg_n = 0110000 for 2 cycles, then 0011001 for 3 cycles → digits[7:4] = 4 only, never 3.
- Full frame: digits 0..3 show 1, 2, 3, 4 for 4 cycles each → digits = 16'h4321, digit_valid = 1111, exactly one frame_done pulse one cycle after digit 3 commits.
- Illegal pattern: after the full frame, digit 1 shows 1111111 for 4 cycles → bad_pattern one pulse, digit_valid = 1101, digits still 16'h4321.
- Overlap and reset: an_n = 1100 for 1 cycle → overlap_err = 1, persisting through later valid frames. Assert reset mid-run → overlap_err = 0, digits = 0.
